// File: rtl/mux_pkg.sv
// Shared constants and types for the N:1 arbitrated output mux.
package mux_pkg;

    localparam int DATA_WIDTH_DEF = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    // Index width that never collapses to zero, so 1- and 2-entry muxes still get a real select.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin or fixed-priority arbiter producing a one-hot grant and its index.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N       = 4,
    parameter bit RR_MODE = 1'b1,
    localparam int SW     = clog2_min1(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] grant_idx
);

    logic [SW-1:0] r_ptr;

    // Scan from the farthest offset down so the nearest request to the pointer wins last.
    always_comb begin
        int w_idx;
        grant     = '0;
        grant_idx = '0;
        w_idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = (RR_MODE ? int'(r_ptr) : 0) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (req[w_idx]) begin
                grant        = '0;
                grant[w_idx] = 1'b1;
                grant_idx    = SW'(w_idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (advance && RR_MODE) begin
            r_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// Registered N:1 data mux: arbitrates valid/ready producers into a 1-entry output stage.
module arb_mux_n
    import mux_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_IN     = 4,
    parameter bit RR_MODE    = 1'b1,
    localparam int SEL_W     = clog2_min1(NUM_IN)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    input  logic                         force_sel_en,
    input  logic [SEL_W-1:0]             force_sel,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SEL_W-1:0]             out_src,
    output stage_state_e                 dbg_state
);

    stage_state_e          r_state;
    stage_state_e          w_state_nxt;
    logic [NUM_IN-1:0]     w_eligible;
    logic [NUM_IN-1:0]     w_grant;
    logic [SEL_W-1:0]      w_grant_idx;
    logic                  w_load_en;
    logic                  w_xfer;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0]      r_out_src;

    // An out-of-range force_sel matches no channel, which blocks every input.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            w_eligible[i] = in_valid[i] & (~force_sel_en | (int'(force_sel) == i));
        end
    end

    rr_arbiter #(
        .N       (NUM_IN),
        .RR_MODE (RR_MODE)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (w_eligible),
        .advance   (w_xfer & ~force_sel_en),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign in_ready   = (reset || !w_load_en) ? '0 : w_grant;
    assign w_xfer     = |in_ready;
    assign w_sel_data = in_data[int'(w_grant_idx)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_xfer) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (r_state == ST_FULL);
        w_load_en = !out_valid || out_ready;
        dbg_state = r_state;
    end

    // Payload only moves on a transfer, so a stalled word stays put with no out_ready path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data <= '0;
            r_out_src  <= '0;
        end else if (w_xfer) begin
            r_out_data <= w_sel_data;
            r_out_src  <= w_grant_idx;
        end
    end

    assign out_data = r_out_data;
    assign out_src  = r_out_src;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n: expected words queued at issue, popped by a monitor on acceptance.
module tb_arb_mux_n;
    import mux_pkg::*;

    localparam int DW = 16;
    localparam int NI = 4;
    localparam int SW = 2;
    localparam int W  = SW + DW;

    logic             clk;
    logic             reset;
    logic [NI*DW-1:0] in_data;
    logic [NI-1:0]    in_valid;
    logic [NI-1:0]    in_ready;
    logic             force_sel_en;
    logic [SW-1:0]    force_sel;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_ready;
    logic [SW-1:0]    out_src;
    stage_state_e     dbg_state;

    logic [NI-1:0]    fp_in_ready;
    logic [DW-1:0]    fp_out_data;
    logic             fp_out_valid;
    logic [SW-1:0]    fp_out_src;
    stage_state_e     fp_dbg_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;
    int total = 0;
    int bad   = 0;

    arb_mux_n #(.DATA_WIDTH(DW), .NUM_IN(NI), .RR_MODE(1'b1)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .force_sel_en(force_sel_en), .force_sel(force_sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src), .dbg_state(dbg_state)
    );

    arb_mux_n #(.DATA_WIDTH(DW), .NUM_IN(NI), .RR_MODE(1'b0)) dut_fp (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(fp_in_ready),
        .force_sel_en(force_sel_en), .force_sel(force_sel), .out_data(fp_out_data),
        .out_valid(fp_out_valid), .out_ready(out_ready), .out_src(fp_out_src), .dbg_state(fp_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int src);
        exp_q.push_back({2'(src), 16'hA000 + 16'(src)});
    endtask

    // scoreboard monitor: one word leaves on each out_valid & out_ready
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL mon_unexpected: got src=%0d data=%h, required no word", out_src, out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("mon_word", {14'd0, out_src, out_data}, {14'd0, mon_exp});
            end
        end
    end

    initial begin
        reset        = 1'b1;
        in_valid     = 4'b1111;
        force_sel_en = 1'b0;
        force_sel    = '0;
        out_ready    = 1'b0;
        for (int i = 0; i < NI; i++) in_data[i*DW +: DW] = 16'hA000 + 16'(i);
        repeat (2) step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_src", out_src, 0);
        reset    = 1'b0;
        in_valid = 4'b0000;
        step();

        // round-robin rotation, one word per cycle
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_in_ready", in_ready, 4'b0001 << (k % 4));
            push(k % 4);
            step();
        end
        in_valid = 4'b0000;
        step();

        // backpressure holds the word, pointer sits at 2 afterwards
        in_valid = 4'b1111;
        #1;
        check("bp_first_grant", in_ready, 4'b0010);
        push(1);
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_src", out_src, 1);
            check("bp_out_data", out_data, 16'hA001);
            check("bp_state", dbg_state, ST_FULL);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_ptr_kept", in_ready, 4'b0100);
        push(2);
        step();
        in_valid = 4'b0000;
        step();
        check("drain_empty", out_valid, 0);

        // forced select; pointer left at 3
        force_sel_en = 1'b1;
        force_sel    = 2'd2;
        in_valid     = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("force_in_ready", in_ready, 4'b0100);
            push(2);
            step();
        end
        in_valid = 4'b1011;
        #1;
        check("force_ineligible", in_ready, 0);
        step();
        force_sel_en = 1'b0;
        in_valid     = 4'b1111;
        #1;
        check("force_ptr_kept", in_ready, 4'b1000);
        push(3);
        step();
        in_valid = 4'b0000;
        step();

        // single-channel requests across the wrap
        in_valid = 4'b0100;
        #1; check("wrap_ch2", in_ready, 4'b0100); push(2); step();
        in_valid = 4'b1000;
        #1; check("wrap_ch3", in_ready, 4'b1000); push(3); step();
        in_valid = 4'b0001;
        #1; check("wrap_ch0", in_ready, 4'b0001); push(0); step();
        in_valid = 4'b1111;
        #1; check("wrap_ptr1", in_ready, 4'b0010); push(1); step();
        in_valid = 4'b0000;
        #1; check("idle_in_ready", in_ready, 0);
        step();

        // fixed priority vs round-robin on 1010, rr pointer starts at 2
        in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("fp_in_ready", fp_in_ready, 4'b0010);
            if (k > 0) begin
                check("fp_out_valid", fp_out_valid, 1);
                check("fp_out_src", fp_out_src, 1);
                check("fp_out_data", fp_out_data, 16'hA001);
            end
            check("rr_1010", in_ready, (k == 1) ? 4'b0010 : 4'b1000);
            push((k == 1) ? 1 : 3);
            step();
        end
        in_valid = 4'b0000;
        step();

        // reset while a word is held; pointer was at 1
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        step();
        in_valid = 4'b1111;
        #1;
        check("pre_rst_full", out_valid, 1);
        #1;
        reset = 1'b1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_out_data", out_data, 0);
        check("async_out_src", out_src, 0);
        check("async_in_ready", in_ready, 0);
        step();
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("rst_ptr_zero", in_ready, 4'b0001);
        push(0);
        step();
        in_valid = 4'b0000;
        repeat (2) step();

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
